// File: rtl/drv_segment_mux_if.sv
// Bus bundle for drv_segment_mux: value/load/enable inputs and the
// segment, decimal-point and anode outputs.
interface drv_segment_mux_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] i_val;
    logic                i_load;
    logic [DIGITS-1:0]   i_dp;
    logic [DIGITS-1:0]   i_en;
    logic                i_hex;
    logic [6:0]          o_drv_sgmnt;
    logic                o_drv_dp;
    logic [DIGITS-1:0]   o_drv_an;

    modport master (
        output i_val, i_load, i_dp, i_en, i_hex,
        input  o_drv_sgmnt, o_drv_dp, o_drv_an
    );

    modport slave (
        input  i_val, i_load, i_dp, i_en, i_hex,
        output o_drv_sgmnt, o_drv_dp, o_drv_an
    );
endinterface

// File: rtl/drv_segment_mux.sv
// Time-multiplexed common-anode 7-segment driver with ghost blanking and
// frame-boundary display updates. Optional: SEGMENT_LZB_EN (leading-zero blanking).
module drv_segment_mux #(
    parameter int DIGITS    = 8,
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input logic              i_clk,
    input logic              i_rst_n,
    drv_segment_mux_if.slave bus
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    function automatic logic [6:0] glyph(input logic [3:0] n, input logic hex);
        case (n)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = hex ? 7'b0001000 : 7'h7F;
            4'hB:    glyph = hex ? 7'b0000011 : 7'h7F;
            4'hC:    glyph = hex ? 7'b1000110 : 7'h7F;
            4'hD:    glyph = hex ? 7'b0100001 : 7'h7F;
            4'hE:    glyph = hex ? 7'b0000110 : 7'h7F;
            default: glyph = hex ? 7'b0001110 : 7'h7F;
        endcase
    endfunction

    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [DIGITS-1:0][3:0] stg_val, disp_val;
    logic [DIGITS-1:0]      stg_dp, disp_dp;
    logic                   pending;
    logic                   slot_end, frame_end;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load on the boundary itself bypasses staging so it lands in the new frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stg_val  <= '0;
            stg_dp   <= '0;
            disp_val <= '0;
            disp_dp  <= '0;
            pending  <= 1'b0;
        end else if (bus.i_load && frame_end) begin
            disp_val <= bus.i_val;
            disp_dp  <= bus.i_dp;
            pending  <= 1'b0;
        end else if (bus.i_load) begin
            stg_val <= bus.i_val;
            stg_dp  <= bus.i_dp;
            pending <= 1'b1;
        end else if (frame_end && pending) begin
            disp_val <= stg_val;
            disp_dp  <= stg_dp;
            pending  <= 1'b0;
        end
    end

    logic lz_hit;
`ifdef SEGMENT_LZB_EN
    logic [DIGITS-1:0] lz;
    logic              zero_run;
    // zero_run stays high while every nibble from the top down to k is zero.
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run && (disp_val[k] == 4'h0);
            lz[k]    = zero_run;
        end
    end
    assign lz_hit = lz[idx];
`else
    assign lz_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_drv_an    <= '1;
            bus.o_drv_sgmnt <= 7'h7F;
            bus.o_drv_dp    <= 1'b1;
        end else if (cnt < CNT_BLANK || !bus.i_en[idx]) begin
            bus.o_drv_an    <= '1;
            bus.o_drv_sgmnt <= 7'h7F;
            bus.o_drv_dp    <= 1'b1;
        end else begin
            bus.o_drv_an    <= ~(DIGITS'(1) << idx);
            bus.o_drv_sgmnt <= lz_hit ? 7'h7F : glyph(disp_val[idx], bus.i_hex);
            bus.o_drv_dp    <= ~disp_dp[idx];
        end
    end
endmodule

// File: tb/tb_drv_segment_mux.sv
// Bench for drv_segment_mux: directed vector table, tear-free/reset sequences,
// and a randomized run against a time-indexed reference model.
module tb_drv_segment_mux;
    localparam int DIGITS    = 4;
    localparam int TICK_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = TICK_DIV * DIGITS;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;
    always #5 i_clk = ~i_clk;

    drv_segment_mux_if #(.DIGITS(DIGITS)) bus();

    drv_segment_mux #(
        .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Model: k = clock edges since reset release (state index); display word
    // plus at most one load waiting for its frame start n_eff.
    int          k = 0;
    logic [15:0] m_val = '0, n_val = '0;
    logic [3:0]  m_dp = '0, n_dp = '0;
    int          n_eff = -1;

    typedef struct {
        string       name;
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        hex;
        int          dig;
        int          c;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dpo;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        int s, c, di;
        logic [3:0] nib, e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        s = k;
        if (n_eff >= 0 && s >= n_eff) begin
            m_val = n_val;
            m_dp  = n_dp;
            n_eff = -1;
        end
        c  = s % TICK_DIV;
        di = (s / TICK_DIV) % DIGITS;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        if (c >= BLANK_CYC && bus.i_en[di]) begin
            e_an[di] = 1'b0;
            nib   = m_val[di*4 +: 4];
            e_seg = (nib > 9 && !bus.i_hex) ? 7'h7F : GLYPH[nib];
`ifdef SEGMENT_LZB_EN
            if (di > 0 && (m_val >> (di * 4)) == 16'h0) e_seg = 7'h7F;
`endif
            e_dp = ~m_dp[di];
        end
        if (bus.i_load) begin
            n_val = bus.i_val;
            n_dp  = bus.i_dp;
            n_eff = FRAME * (s / FRAME + 1);
        end
        @(posedge i_clk);
        k++;
        #1;
        chk("model_an", bus.o_drv_an, e_an);
        chk("model_seg", bus.o_drv_sgmnt, e_seg);
        chk("model_dp", bus.o_drv_dp, e_dp);
        bus.i_load = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n    = 1'b0;
        bus.i_load = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_an", bus.o_drv_an, 4'hF);
        chk("reset_seg", bus.o_drv_sgmnt, 7'h7F);
        chk("reset_dp", bus.o_drv_dp, 1'b1);
        i_rst_n = 1'b1;
        k = 0; m_val = '0; m_dp = '0; n_eff = -1;
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        bus.i_val  = v;
        bus.i_dp   = d;
        bus.i_load = 1'b1;
        step();
    endtask

    task automatic wait_frame();
        for (int i = 0; i < FRAME && (k % FRAME) != 0; i++) step();
    endtask

    // Step until the output shows state (digit d, count c).
    task automatic run_to(input int d, input int c);
        int n = 0;
        do begin
            step();
            n++;
        end while (((k - 1) % FRAME) != d * TICK_DIV + c && n < 2 * FRAME);
        if (n >= 2 * FRAME) begin
            failures++;
            $display("FAIL run_to timeout d=%0d c=%0d", d, c);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] an, input logic [6:0] seg,
                           input logic dpo);
        chk({nm, "_an"}, bus.o_drv_an, an);
        chk({nm, "_seg"}, bus.o_drv_sgmnt, seg);
        chk({nm, "_dp"}, bus.o_drv_dp, dpo);
    endtask

    initial begin
        vecs.push_back('{"dec_d0",   16'h1234, 4'b0010, 4'hF, 1'b0, 0, 4, 4'b1110, 7'b0011001, 1'b1});
        vecs.push_back('{"dec_d1",   16'h1234, 4'b0010, 4'hF, 1'b0, 1, 4, 4'b1101, 7'b0110000, 1'b0});
        vecs.push_back('{"dec_d3",   16'h1234, 4'b0010, 4'hF, 1'b0, 3, 7, 4'b0111, 7'b1111001, 1'b1});
        vecs.push_back('{"ghost_c0", 16'h1234, 4'b0010, 4'hF, 1'b0, 1, 0, 4'b1111, 7'h7F,      1'b1});
        vecs.push_back('{"ghost_c1", 16'h1234, 4'b0010, 4'hF, 1'b0, 1, 1, 4'b1111, 7'h7F,      1'b1});
        vecs.push_back('{"hex_d0",   16'hABCD, 4'b0000, 4'hF, 1'b1, 0, 4, 4'b1110, 7'b0100001, 1'b1});
        vecs.push_back('{"hex_d1",   16'hABCD, 4'b0000, 4'hF, 1'b1, 1, 4, 4'b1101, 7'b1000110, 1'b1});
        vecs.push_back('{"hex_d2",   16'hABCD, 4'b0000, 4'hF, 1'b1, 2, 4, 4'b1011, 7'b0000011, 1'b1});
        vecs.push_back('{"hex_d3",   16'hABCD, 4'b0000, 4'hF, 1'b1, 3, 4, 4'b0111, 7'b0001000, 1'b1});
        vecs.push_back('{"dechi_d2", 16'hABCD, 4'b0100, 4'hF, 1'b0, 2, 4, 4'b1011, 7'h7F,      1'b0});
        vecs.push_back('{"en_off",   16'h1234, 4'b0100, 4'b1011, 1'b0, 2, 5, 4'b1111, 7'h7F,   1'b1});
        vecs.push_back('{"en_other", 16'h1234, 4'b0100, 4'b1011, 1'b0, 3, 5, 4'b0111, 7'b1111001, 1'b1});
`ifdef SEGMENT_LZB_EN
        vecs.push_back('{"lzb45_d3", 16'h0045, 4'b0000, 4'hF, 1'b0, 3, 4, 4'b0111, 7'h7F,      1'b1});
        vecs.push_back('{"lzb45_d2", 16'h0045, 4'b1000, 4'hF, 1'b0, 2, 4, 4'b1011, 7'h7F,      1'b1});
        vecs.push_back('{"lzb45_d1", 16'h0045, 4'b0000, 4'hF, 1'b0, 1, 4, 4'b1101, 7'b0011001, 1'b1});
        vecs.push_back('{"lzb45_d0", 16'h0045, 4'b0000, 4'hF, 1'b0, 0, 4, 4'b1110, 7'b0010010, 1'b1});
        vecs.push_back('{"lzb0_d0",  16'h0000, 4'b0000, 4'hF, 1'b0, 0, 4, 4'b1110, 7'b1000000, 1'b1});
        vecs.push_back('{"lzb0_d1",  16'h0000, 4'b0010, 4'hF, 1'b0, 1, 4, 4'b1101, 7'h7F,      1'b0});
`else
        vecs.push_back('{"lz45_d3",  16'h0045, 4'b0000, 4'hF, 1'b0, 3, 4, 4'b0111, 7'b1000000, 1'b1});
`endif

        bus.i_val = '0; bus.i_dp = '0; bus.i_en = 4'hF; bus.i_hex = 1'b0; bus.i_load = 1'b0;
        #1;
        do_reset();
        for (int i = 0; i < BLANK_CYC; i++) step();

        foreach (vecs[i]) begin
            bus.i_en  = vecs[i].en;
            bus.i_hex = vecs[i].hex;
            load(vecs[i].val, vecs[i].dp);
            wait_frame();
            run_to(vecs[i].dig, vecs[i].c);
            chk_out(vecs[i].name, vecs[i].an, vecs[i].seg, vecs[i].dpo);
        end

        // Digit 2 disabled: dark for its whole slot.
        bus.i_en = 4'b1011;
        for (int c = 0; c < TICK_DIV; c++) begin
            run_to(2, c);
            chk("en_slot_an", bus.o_drv_an, 4'hF);
        end
        bus.i_en = 4'hF;

        // Mid-frame load waits for the next frame.
        load(16'h1111, 4'h0);
        wait_frame();
        run_to(1, 0);
        load(16'h2222, 4'h0);
        run_to(2, 4);
        chk_out("tear_d2", 4'b1011, 7'b1111001, 1'b1);
        run_to(3, 4);
        chk_out("tear_d3", 4'b0111, 7'b1111001, 1'b1);
        run_to(0, 4);
        chk_out("tear_next", 4'b1110, 7'b0100100, 1'b1);

        // Load on the boundary cycle shows in the new frame at once.
        for (int i = 0; i < FRAME && (k % FRAME) != FRAME - 1; i++) step();
        load(16'h3333, 4'h0);
        run_to(0, 4);
        chk_out("bnd_d0", 4'b1110, 7'b0110000, 1'b1);

        // Async reset mid-slot discards a pending load.
        run_to(1, 5);
        load(16'h7777, 4'hF);
        i_rst_n = 1'b0;
        #2;
        chk_out("async_rst", 4'hF, 7'h7F, 1'b1);
        do_reset();
        run_to(0, 4);
        chk_out("post_rst_d0", 4'b1110, 7'b1000000, 1'b1);
        run_to(0, 4);
        chk_out("post_rst_f1", 4'b1110, 7'b1000000, 1'b1);

        // Randomized run against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) begin
                bus.i_val  = 16'($urandom);
                bus.i_dp   = 4'($urandom);
                bus.i_load = 1'b1;
            end
            if ($urandom_range(63) == 0) bus.i_en = ($urandom_range(1) == 0) ? 4'hF : 4'($urandom);
            if ($urandom_range(31) == 0) bus.i_hex = 1'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
